// File: rtl/ring_osc_measure_sequencer.sv
// On-chip measurement sequencer for the instrumented adder: runs reset/load/settle/run/capture
// cycles a programmable number of times and accumulates sum, min and max of the ring counts.
module ring_osc_measure_sequencer #(
  parameter int COUNT_W      = 32,
  parameter int RUN_W        = 4,
  parameter int RESET_CYCLES = 2,
  parameter int TIMEOUT_W    = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [RUN_W-1:0]         cfg_runs,
  input  logic [COUNT_W-1:0]       cfg_integration,
  input  logic [7:0]               cfg_settle,
  output logic                     dut_reset,
  output logic                     dut_stop_b,
  output logic                     dut_counter_load,
  output logic                     dut_counter_enable,
  output logic [COUNT_W-1:0]       dut_integration,
  input  logic                     dut_done,
  input  logic [COUNT_W-1:0]       dut_count,
  output logic                     busy,
  output logic                     result_valid,
  output logic                     result_timeout,
  output logic [RUN_W-1:0]         result_runs,
  output logic [COUNT_W+RUN_W-1:0] result_sum,
  output logic [COUNT_W-1:0]       result_min,
  output logic [COUNT_W-1:0]       result_max
);

  localparam int SUM_W = COUNT_W + RUN_W;
  localparam logic [7:0] CLEAR_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_CAPTURE,
    S_FINISH
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [7:0]           phase_cnt;
  logic [TIMEOUT_W-1:0] watchdog;
  logic [RUN_W-1:0]     runs_cfg;
  logic [7:0]           settle_cfg;
  logic [COUNT_W-1:0]   integ_cfg;
  logic                 run_timed_out;
  logic [RUN_W-1:0]     runs_inc;
  logic                 wd_hit;
  logic                 last_run;

  assign runs_inc        = result_runs + RUN_W'(1);
  assign last_run        = (runs_inc >= runs_cfg);
  // The run ends on the cycle whose increment would make the watchdog all-ones.
  assign wd_hit          = (watchdog == WD_LAST);
  assign dut_integration = integ_cfg;

  always_comb begin
    state_n            = state;
    dut_reset          = 1'b0;
    dut_stop_b         = 1'b0;
    dut_counter_load   = 1'b0;
    dut_counter_enable = 1'b0;
    busy               = 1'b1;
    result_valid       = 1'b0;
    case (state)
      S_IDLE: begin
        dut_reset = 1'b1;
        busy      = 1'b0;
        if (start) state_n = S_CLEAR;
      end
      S_CLEAR: begin
        dut_reset = 1'b1;
        if (phase_cnt == 8'd0) state_n = S_LOAD;
      end
      S_LOAD: begin
        dut_counter_load = 1'b1;
        state_n = (settle_cfg == 8'd0) ? S_RUN : S_SETTLE;
      end
      S_SETTLE: begin
        dut_stop_b = 1'b1;
        if (phase_cnt == 8'd0) state_n = S_RUN;
      end
      S_RUN: begin
        dut_stop_b         = 1'b1;
        dut_counter_enable = 1'b1;
        if (dut_done || wd_hit) state_n = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_n = (run_timed_out || last_run) ? S_FINISH : S_CLEAR;
      end
      S_FINISH: begin
        dut_reset    = 1'b1;
        result_valid = 1'b1;
        state_n      = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (abort) state_n = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      phase_cnt      <= 8'd0;
      watchdog       <= '0;
      runs_cfg       <= '0;
      settle_cfg     <= 8'd0;
      integ_cfg      <= '0;
      run_timed_out  <= 1'b0;
      result_timeout <= 1'b0;
      result_runs    <= '0;
      result_sum     <= '0;
      result_min     <= '1;
      result_max     <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            runs_cfg       <= (cfg_runs == '0) ? RUN_W'(1) : cfg_runs;
            settle_cfg     <= cfg_settle;
            integ_cfg      <= cfg_integration;
            phase_cnt      <= CLEAR_LAST;
            result_timeout <= 1'b0;
            result_runs    <= '0;
            result_sum     <= '0;
            result_min     <= '1;
            result_max     <= '0;
          end
        end
        S_CLEAR: begin
          if (phase_cnt != 8'd0) phase_cnt <= phase_cnt - 8'd1;
        end
        S_LOAD: begin
          phase_cnt <= settle_cfg - 8'd1;
          watchdog  <= '0;
        end
        S_SETTLE: begin
          watchdog <= '0;
          if (phase_cnt != 8'd0) phase_cnt <= phase_cnt - 8'd1;
        end
        S_RUN: begin
          watchdog      <= watchdog + TIMEOUT_W'(1);
          run_timed_out <= !dut_done;
        end
        S_CAPTURE: begin
          // An aborted capture leaves the partial results untouched.
          if (!abort) begin
            phase_cnt <= CLEAR_LAST;
            if (run_timed_out) begin
              result_timeout <= 1'b1;
            end else begin
              result_runs <= runs_inc;
              result_sum  <= result_sum + SUM_W'(dut_count);
              if (dut_count < result_min) result_min <= dut_count;
              if (dut_count > result_max) result_max <= dut_count;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_osc_measure_sequencer.sv
// Directed self-checking bench for ring_osc_measure_sequencer with a behavioural adder model;
// a second instance with a 6-bit watchdog covers the timeout path.
module tb_ring_osc_measure_sequencer;

  localparam int COUNT_W = 32;
  localparam int RUN_W   = 4;
  localparam int SUM_W   = COUNT_W + RUN_W;

  logic clk = 1'b0;
  logic reset, start, start_t, abort, never_done;
  logic [RUN_W-1:0]   cfg_runs;
  logic [COUNT_W-1:0] cfg_integration;
  logic [7:0]         cfg_settle;

  logic a_rst, a_stop, a_load, a_en, a_busy, a_valid, a_timeout;
  logic [RUN_W-1:0]   a_runs;
  logic [SUM_W-1:0]   a_sum;
  logic [COUNT_W-1:0] a_min, a_max, a_integ;

  logic b_rst, b_stop, b_load, b_en, b_busy, b_valid, b_timeout;
  logic [RUN_W-1:0]   b_runs;
  logic [SUM_W-1:0]   b_sum;
  logic [COUNT_W-1:0] b_min, b_max, b_integ;

  logic               m_done  = 1'b0;
  logic [COUNT_W-1:0] m_count = '0;

  int checks = 0;
  int errors = 0;
  int en_cycles = 0, done_delay = 100, load_num = 0, streak = 0, valid_cnt = 0;
  logic [COUNT_W-1:0] count_tab [0:31];
  int streak_at_load [0:31];

  always #5 clk = ~clk;

  ring_osc_measure_sequencer #(.COUNT_W(COUNT_W), .RUN_W(RUN_W), .RESET_CYCLES(2), .TIMEOUT_W(24)) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_runs(cfg_runs), .cfg_integration(cfg_integration), .cfg_settle(cfg_settle),
    .dut_reset(a_rst), .dut_stop_b(a_stop), .dut_counter_load(a_load), .dut_counter_enable(a_en),
    .dut_integration(a_integ), .dut_done(m_done), .dut_count(m_count),
    .busy(a_busy), .result_valid(a_valid), .result_timeout(a_timeout), .result_runs(a_runs),
    .result_sum(a_sum), .result_min(a_min), .result_max(a_max)
  );

  ring_osc_measure_sequencer #(.COUNT_W(COUNT_W), .RUN_W(RUN_W), .RESET_CYCLES(2), .TIMEOUT_W(6)) dut_b (
    .clk(clk), .reset(reset), .start(start_t), .abort(abort),
    .cfg_runs(cfg_runs), .cfg_integration(cfg_integration), .cfg_settle(cfg_settle),
    .dut_reset(b_rst), .dut_stop_b(b_stop), .dut_counter_load(b_load), .dut_counter_enable(b_en),
    .dut_integration(b_integ), .dut_done(never_done), .dut_count(m_count),
    .busy(b_busy), .result_valid(b_valid), .result_timeout(b_timeout), .result_runs(b_runs),
    .result_sum(b_sum), .result_min(b_min), .result_max(b_max)
  );

  // Adder model: done after done_delay enabled cycles, count chosen per load; plus monitors.
  always @(negedge clk) begin
    if (a_valid) valid_cnt++;
    if (a_load) begin
      streak_at_load[load_num % 32] = streak;
      m_count = count_tab[load_num % 32];
      load_num++;
    end
    streak = (a_busy && a_rst) ? streak + 1 : 0;
    if (a_rst) begin
      en_cycles = 0;
      m_done    = 1'b0;
    end else if (a_en) begin
      en_cycles++;
      if (en_cycles >= done_delay) m_done = 1'b1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [RUN_W-1:0] runs, input logic [COUNT_W-1:0] integ,
                               input logic [7:0] settle, input bit use_b);
    cfg_runs        = runs;
    cfg_integration = integ;
    cfg_settle      = settle;
    if (use_b) start_t = 1'b1;
    else       start   = 1'b1;
    tick();
    start   = 1'b0;
    start_t = 1'b0;
  endtask

  initial begin
    int lat, base_load, base_valid, en_cnt, b_pulses;
    reset = 1'b1; start = 1'b0; start_t = 1'b0; abort = 1'b0; never_done = 1'b0;
    cfg_runs = '0; cfg_integration = '0; cfg_settle = 8'd0;
    for (int i = 0; i < 32; i++) count_tab[i] = '0;
    tick();
    tick();
    checkOutput("rst_dut_reset", 64'(a_rst), 64'd1);
    checkOutput("rst_stop_b",    64'(a_stop), 64'd0);
    checkOutput("rst_busy",      64'(a_busy), 64'd0);
    checkOutput("rst_min",       64'(a_min), 64'hFFFF_FFFF);
    checkOutput("rst_sum",       64'(a_sum), 64'd0);
    reset = 1'b0;
    tick();

    // Single run: settle 4, done after 100 enabled cycles, count 0x1234
    done_delay = 100;
    count_tab[load_num % 32] = 32'h1234;
    base_valid = valid_cnt;
    applyStimulus(4'd1, 32'h5000, 8'd4, 1'b0);
    lat = 1;
    while (!a_valid && lat < 400) begin tick(); lat++; end
    checkOutput("single_latency", 64'(lat), 64'd109);
    checkOutput("single_sum",     64'(a_sum), 64'h1234);
    checkOutput("single_min",     64'(a_min), 64'h1234);
    checkOutput("single_max",     64'(a_max), 64'h1234);
    checkOutput("single_runs",    64'(a_runs), 64'd1);
    checkOutput("single_timeout", 64'(a_timeout), 64'd0);
    checkOutput("single_integ",   64'(a_integ), 64'h5000);
    tick();
    checkOutput("single_valid_drop", 64'(a_valid), 64'd0);
    checkOutput("single_idle",       64'(a_busy), 64'd0);
    checkOutput("single_sum_hold",   64'(a_sum), 64'h1234);
    tick();
    checkOutput("single_valid_once", 64'(valid_cnt - base_valid), 64'd1);

    // Multi run with zero settle: counts 10, 30, 20
    done_delay = 5;
    base_load = load_num;
    count_tab[(base_load + 0) % 32] = 32'd10;
    count_tab[(base_load + 1) % 32] = 32'd30;
    count_tab[(base_load + 2) % 32] = 32'd20;
    applyStimulus(4'd3, 32'h100, 8'd0, 1'b0);
    lat = 1;
    while (!a_valid && lat < 400) begin tick(); lat++; end
    checkOutput("multi_wait", 64'(lat < 400), 64'd1);
    checkOutput("multi_sum",  64'(a_sum), 64'd60);
    checkOutput("multi_min",  64'(a_min), 64'd10);
    checkOutput("multi_max",  64'(a_max), 64'd30);
    checkOutput("multi_runs", 64'(a_runs), 64'd3);
    checkOutput("multi_loads", 64'(load_num - base_load), 64'd3);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("multi_clear_len%0d", i), 64'(streak_at_load[(base_load + i) % 32]), 64'd2);
    tick();

    // Timeout on the 6-bit watchdog instance; done never comes
    applyStimulus(4'd2, 32'h0, 8'd0, 1'b1);
    lat = 1; en_cnt = 0; b_pulses = 0;
    while (!b_valid && lat < 300) begin
      if (b_en) en_cnt++;
      tick();
      lat++;
    end
    checkOutput("tmo_wait",     64'(lat < 300), 64'd1);
    checkOutput("tmo_run_len",  64'(en_cnt), 64'd63);
    checkOutput("tmo_flag",     64'(b_timeout), 64'd1);
    checkOutput("tmo_runs",     64'(b_runs), 64'd0);
    checkOutput("tmo_min",      64'(b_min), 64'hFFFF_FFFF);
    for (int i = 0; i < 20; i++) begin
      if (b_valid) b_pulses++;
      tick();
    end
    checkOutput("tmo_one_pulse", 64'(b_pulses), 64'd1);
    checkOutput("tmo_sticky",    64'(b_timeout), 64'd1);
    checkOutput("tmo_idle",      64'(b_busy), 64'd0);

    // Abort during RUN of run 2 of 3
    done_delay = 5;
    base_load = load_num;
    base_valid = valid_cnt;
    count_tab[(base_load + 0) % 32] = 32'd7;
    count_tab[(base_load + 1) % 32] = 32'd8;
    count_tab[(base_load + 2) % 32] = 32'd9;
    applyStimulus(4'd3, 32'h0, 8'd1, 1'b0);
    lat = 1;
    while (!(load_num == base_load + 2 && a_en) && lat < 400) begin tick(); lat++; end
    checkOutput("abort_reach_run", 64'(lat < 400), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_dut_reset", 64'(a_rst), 64'd1);
    checkOutput("abort_enable",    64'(a_en), 64'd0);
    checkOutput("abort_busy",      64'(a_busy), 64'd0);
    checkOutput("abort_runs",      64'(a_runs), 64'd1);
    checkOutput("abort_sum",       64'(a_sum), 64'd7);
    for (int i = 0; i < 60; i++) tick();
    checkOutput("abort_no_valid",  64'(valid_cnt - base_valid), 64'd0);

    // cfg_runs=0 acts as one run; start and config changes while busy are ignored
    done_delay = 3;
    base_load = load_num;
    base_valid = valid_cnt;
    count_tab[base_load % 32] = 32'h55;
    count_tab[(base_load + 1) % 32] = 32'h99;
    applyStimulus(4'd0, 32'h0, 8'd2, 1'b0);
    tick(); tick(); tick();
    start = 1'b1; cfg_runs = 4'd5;
    tick();
    start = 1'b0;
    lat = 1;
    while (!a_valid && lat < 400) begin tick(); lat++; end
    checkOutput("zero_runs_wait", 64'(lat < 400), 64'd1);
    checkOutput("zero_runs_runs", 64'(a_runs), 64'd1);
    checkOutput("zero_runs_sum",  64'(a_sum), 64'h55);
    for (int i = 0; i < 40; i++) tick();
    checkOutput("zero_runs_loads", 64'(load_num - base_load), 64'd1);
    checkOutput("zero_runs_valid", 64'(valid_cnt - base_valid), 64'd1);
    checkOutput("zero_runs_idle",  64'(a_busy), 64'd0);

    // Async reset while in SETTLE
    base_valid = valid_cnt;
    count_tab[load_num % 32] = 32'h42;
    applyStimulus(4'd1, 32'h0, 8'd10, 1'b0);
    lat = 1;
    while (!a_stop && lat < 100) begin tick(); lat++; end
    checkOutput("areset_reach_settle", 64'(lat < 100), 64'd1);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("areset_dut_reset", 64'(a_rst), 64'd1);
    checkOutput("areset_stop_b",    64'(a_stop), 64'd0);
    checkOutput("areset_busy",      64'(a_busy), 64'd0);
    checkOutput("areset_min",       64'(a_min), 64'hFFFF_FFFF);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    checkOutput("areset_no_valid",  64'(valid_cnt - base_valid), 64'd0);
    checkOutput("areset_stay_idle", 64'(a_busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
